// File: rtl/y_arb_pkg.sv
// Shared types and helpers for the y_wrr_arbiter column arbiter.
// Optional weighting is enabled with the YARB_WEIGHT_EN macro.
package y_arb_pkg;

  typedef enum logic {IDLE, GRANT} yarb_state_e;

  localparam int W_WIDTH_DEF = 2;
  localparam int IDX_MAX     = 64;

  function automatic int unsigned onehot2idx(
    input logic [IDX_MAX-1:0] oh
  );
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < IDX_MAX; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/y_prio_pick.sv
// Lowest-index fixed-priority pick: one-hot winner plus any flag.
// Used twice by y_wrr_arbiter (masked and unmasked request sets).
module y_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  // two's complement isolates the lowest set bit
  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;

endmodule

// File: rtl/y_wrr_arbiter.sv
// Weighted round-robin column arbiter with grant-hold/ack handshake.
// Define YARB_WEIGHT_EN to add weight_i and multi-ack burst credits.
module y_wrr_arbiter
  import y_arb_pkg::*;
#(
  parameter int COLS    = 4,
  parameter int Y_WIDTH = $clog2(COLS),
  parameter int W_WIDTH = W_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [COLS-1:0]         req_i,
`ifdef YARB_WEIGHT_EN
  input  logic [COLS*W_WIDTH-1:0] weight_i,
`endif
  input  logic                    ack_i,
  output logic                    gnt_valid_o,
  output logic [COLS-1:0]         gnt_o,
  output logic [Y_WIDTH-1:0]      yadd_o
);

`ifdef YARB_WEIGHT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  localparam int CW = WEN ? W_WIDTH : 1;

  yarb_state_e     state_q;
  logic [COLS-1:0] mask_q;
  logic [CW-1:0]   credit_q;

  logic [COLS-1:0] adv_mask;
  logic [COLS-1:0] pick_req;
  logic [COLS-1:0] pick_msk;
  logic [COLS-1:0] m_oh;
  logic [COLS-1:0] u_oh;
  logic            m_any;
  logic            u_any;
  logic [COLS-1:0] win_oh;
  logic [Y_WIDTH-1:0] win_idx;
  logic [IDX_MAX-1:0] win_pad;
  logic [CW-1:0]   win_w;
  logic            cur_req;
  logic            burst;
  logic            release_g;

  always_comb begin
    adv_mask = '1;
    for (int j = 0; j < COLS; j++) begin
      if (j <= int'(yadd_o)) adv_mask[j] = 1'b0;
    end
    if (yadd_o == Y_WIDTH'(COLS-1)) adv_mask = '1;
  end

  // in GRANT the re-pick sees the advanced mask and skips the current column
  always_comb begin
    pick_req = req_i;
    pick_msk = mask_q;
    if (state_q == GRANT) begin
      pick_req = req_i & ~gnt_o;
      pick_msk = adv_mask;
    end
  end

  y_prio_pick #(.N(COLS)) u_pick_m (
    .req_i (pick_req & pick_msk),
    .gnt_o (m_oh),
    .any_o (m_any)
  );

  y_prio_pick #(.N(COLS)) u_pick_u (
    .req_i (pick_req),
    .gnt_o (u_oh),
    .any_o (u_any)
  );

  assign win_oh  = m_any ? m_oh : u_oh;
  assign win_pad = IDX_MAX'(win_oh);
  assign win_idx = Y_WIDTH'(onehot2idx(win_pad));

`ifdef YARB_WEIGHT_EN
  always_comb begin
    win_w = '0;
    for (int i = 0; i < COLS; i++) begin
      if (win_oh[i]) win_w = weight_i[i*W_WIDTH+:W_WIDTH];
    end
    if (win_w == '0) win_w = CW'(1);
  end
`else
  assign win_w = CW'(1);
`endif

  always_comb begin
    cur_req   = |(req_i & gnt_o);
    burst     = ack_i && cur_req
             && (credit_q > CW'(1));
    release_g = !burst && (ack_i || !cur_req);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      state_q     <= IDLE;
      mask_q      <= '1;
      credit_q    <= '0;
      gnt_o       <= '0;
      yadd_o      <= '0;
      gnt_valid_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (u_any) begin
            state_q     <= GRANT;
            gnt_o       <= win_oh;
            yadd_o      <= win_idx;
            gnt_valid_o <= 1'b1;
            credit_q    <= win_w;
          end
        end
        GRANT: begin
          if (burst) begin
            credit_q <= credit_q - CW'(1);
          end else if (release_g) begin
            mask_q <= adv_mask;
            if (u_any) begin
              gnt_o    <= win_oh;
              yadd_o   <= win_idx;
              credit_q <= win_w;
            end else begin
              state_q     <= IDLE;
              gnt_o       <= '0;
              yadd_o      <= '0;
              gnt_valid_o <= 1'b0;
              credit_q    <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
